// File: rtl/ps2_rx_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_rx_ctrl
//
// Receive sequencer for the PS/2 keyboard path. Consumes the debounced PS/2
// clock and data lines and walks the 11-bit device-to-host frame:
//   start(0), d0..d7 (LSB first), odd parity, stop(1).
// The received scan-code byte is offered to the downstream decoder on a
// valid/ready handshake. Protocol problems are reported as single-cycle
// registered pulses.
//
// Optional build macro:
//   PS2_RX_PARITY_CHECK_EN  - when defined, the parity bit is checked (odd
//                             parity) and a mismatch drops the byte with an
//                             err_parity pulse. When undefined, the parity bit
//                             is still clocked in but ignored, and err_parity
//                             is constant 0.
//
// Parameters:
//   TIMEOUT_CYCLES - clk cycles allowed between PS/2 clock falls inside a
//                    frame before the frame is abandoned (>= 2)
//   CNT_W          - timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active high
//   ps2_clk      debounced PS/2 clock, synchronous to clk
//   ps2_data     debounced PS/2 data, synchronous to clk
//   rx_data      received byte, valid while rx_valid = 1
//   rx_valid     byte available, held until accepted
//   rx_ready     consumer accepts rx_data when rx_valid & rx_ready
//   busy         1 while a frame is in progress (state != IDLE)
//   err_parity   pulse: parity mismatch, byte dropped
//   err_frame    pulse: stop bit sampled 0, byte dropped
//   err_timeout  pulse: frame abandoned, PS/2 clock stalled
//   err_overrun  pulse: good byte dropped, holding register still full
// ---------------------------------------------------------------------------
module ps2_rx_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       err_parity,
   output logic       err_frame,
   output logic       err_timeout,
   output logic       err_overrun
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

`ifdef PS2_RX_PARITY_CHECK_EN
   localparam logic PAR_CHK = 1'b1;
`else
   localparam logic PAR_CHK = 1'b0;
`endif

   // Last counter value tolerated without a falling edge.
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           state_q;
   logic             clk_prev_q;
   logic [3:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic             par_q;
   logic [CNT_W-1:0] tmo_cnt_q;

   logic [7:0]       rx_data_q;
   logic             rx_valid_q;
   logic             busy_q;
   logic             err_parity_q;
   logic             err_frame_q;
   logic             err_timeout_q;
   logic             err_overrun_q;

   // ------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------
   logic       fall;
   logic       tmo_hit;
   logic       stop_fall;
   logic       parity_bad;
   logic       frame_bad_d;
   logic       parity_err_d;
   logic       byte_ok;
   logic       deliver;
   logic       overrun_d;
   logic [7:0] rx_data_d;
   logic       rx_valid_d;

   always_comb begin
      fall      = clk_prev_q & ~ps2_clk;

      // The stall counter only matters inside a frame; a fall in the same
      // cycle always wins over an expiring counter.
      tmo_hit   = (state_q != S_IDLE) & ~fall & (tmo_cnt_q == TMO_LAST);

      stop_fall = fall & (state_q == S_STOP);

      // Odd parity over the eight data bits plus the parity bit. With the
      // check compiled out this collapses to constant 0.
      parity_bad = PAR_CHK & ~(^{shift_q, par_q});

      // A bad stop bit masks a parity error: only err_frame is reported.
      frame_bad_d  = stop_fall & ~ps2_data;
      parity_err_d = stop_fall &  ps2_data & parity_bad;
      byte_ok      = stop_fall &  ps2_data & ~parity_bad;

      // A consumer taking the old byte in the same cycle frees the holding
      // register, so the new byte can be loaded without loss.
      deliver   = byte_ok & (~rx_valid_q | rx_ready);
      overrun_d = byte_ok &  rx_valid_q & ~rx_ready;

      rx_data_d  = deliver ? shift_q : rx_data_q;
      rx_valid_d = deliver | (rx_valid_q & ~rx_ready);
   end

   // ------------------------------------------------------------------
   // Frame FSM, timeout counter and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         clk_prev_q    <= 1'b1;
         bit_cnt_q     <= 4'd0;
         shift_q       <= 8'h00;
         par_q         <= 1'b0;
         tmo_cnt_q     <= '0;
         rx_data_q     <= 8'h00;
         rx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         err_parity_q  <= 1'b0;
         err_frame_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         clk_prev_q    <= ps2_clk;

         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;

         err_parity_q  <= parity_err_d;
         err_frame_q   <= frame_bad_d;
         err_timeout_q <= tmo_hit;
         err_overrun_q <= overrun_d;

         // Stall counter: held at 0 when idle, restarted by every fall.
         if ((state_q == S_IDLE) || fall || tmo_hit) begin
            tmo_cnt_q <= '0;
         end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
         end

         if (tmo_hit) begin
            // Abandon the partial frame; the shift register content is
            // simply overwritten by the next frame.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else if (fall) begin
            case (state_q)
               S_IDLE: begin
                  // A fall with data high is a line glitch, not a start bit.
                  if (!ps2_data) begin
                     state_q   <= S_DATA;
                     busy_q    <= 1'b1;
                     bit_cnt_q <= 4'd0;
                  end
               end

               S_DATA: begin
                  shift_q   <= {ps2_data, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     state_q <= S_PARITY;
                  end
               end

               S_PARITY: begin
                  par_q   <= ps2_data;
                  state_q <= S_STOP;
               end

               S_STOP: begin
                  // Byte disposition is handled by the decode above.
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end

               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = busy_q;
   assign err_parity  = err_parity_q;
   assign err_frame   = err_frame_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_ctrl
//
// Scoreboard bench for ps2_rx_ctrl. The stimulus side drives PS/2 frames and,
// at each stop-bit fall, asks a frame-level reference model what must happen
// (byte delivered, or which error). Expected bytes and error events go into
// queues; an independent monitor pops and compares whenever the DUT accepts
// a byte or raises an error pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_rx_ctrl;

   localparam int TMO  = 100;
   localparam int HALF = 20;     // PS/2 clock half period in clk cycles

   localparam int E_PARITY  = 1;
   localparam int E_FRAME   = 2;
   localparam int E_TIMEOUT = 3;
   localparam int E_OVERRUN = 4;

`ifdef PS2_RX_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       err_parity;
   logic       err_frame;
   logic       err_timeout;
   logic       err_overrun;

   int          n_checks = 0;
   int          n_pass   = 0;
   int unsigned cyc      = 0;
   int unsigned last_fall_cyc = 0;

   logic [7:0] exp_bytes[$];
   int         exp_errs[$];
   bit         model_full = 1'b0;   // reference: holding register occupied
   bit         rdy_rand   = 1'b0;
   logic       rdy_fixed  = 1'b1;

   ps2_rx_ctrl #(
      .TIMEOUT_CYCLES(TMO),
      .CNT_W(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .busy       (busy),
      .err_parity (err_parity),
      .err_frame  (err_frame),
      .err_timeout(err_timeout),
      .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic got_err(input int code, input string name);
      int front;
      n_checks++;
      front = (exp_errs.size() != 0) ? exp_errs[0] : 0;
      if (exp_errs.size() != 0 && front == code) begin
         void'(exp_errs.pop_front());
         n_pass++;
      end else begin
         $display("FAIL %s: got pulse code %0d, expected code %0d (0 = none)", name, code, front);
         if (exp_errs.size() != 0) void'(exp_errs.pop_front());
      end
   endtask

   // rx_ready driver: changes just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
      end
   end

   // Monitor: byte acceptance, error pulses, hold stability.
   initial begin
      logic       hold_prev;
      logic [7:0] data_prev;
      logic [7:0] expb;
      hold_prev = 1'b0;
      data_prev = 8'h00;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev) begin
               check("hold_valid", rx_valid, 1);
               check("hold_data", rx_data, data_prev);
            end
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
               n_checks++;
               if (exp_bytes.size() == 0) begin
                  $display("FAIL rx_byte: got 0x%02h, expected no byte", rx_data);
               end else begin
                  expb = exp_bytes.pop_front();
                  if (rx_data === expb) n_pass++;
                  else $display("FAIL rx_byte: got 0x%02h, expected 0x%02h", rx_data, expb);
               end
               model_full = 1'b0;
            end
            if (err_parity  === 1'b1) got_err(E_PARITY,  "err_parity");
            if (err_frame   === 1'b1) got_err(E_FRAME,   "err_frame");
            if (err_timeout === 1'b1) got_err(E_TIMEOUT, "err_timeout");
            if (err_overrun === 1'b1) got_err(E_OVERRUN, "err_overrun");
            hold_prev = (rx_valid === 1'b1) && (rx_ready !== 1'b1);
            data_prev = rx_data;
         end
      end
   end

   // Frame-level reference: decides the outcome of a complete frame.
   task automatic predict(input logic [7:0] b, input logic par, input logic stop, output bit dlv);
      bit par_good;
      dlv = 1'b0;
      par_good = ($countones({b, par}) % 2) == 1;
      if (!stop)                        exp_errs.push_back(E_FRAME);
      else if (PAR_EN && !par_good)     exp_errs.push_back(E_PARITY);
      else if (model_full && !rx_ready) exp_errs.push_back(E_OVERRUN);
      else begin
         exp_bytes.push_back(b);
         model_full = 1'b1;
         dlv = 1'b1;
      end
   endtask

   task automatic drive_fall(input logic d);
      @(posedge clk); #1;
      ps2_data = d;
      repeat (HALF) @(posedge clk);
      #1;
      ps2_clk = 1'b0;
   endtask

   task automatic release_clk();
      repeat (HALF) @(posedge clk);
      #1;
      ps2_clk = 1'b1;
   endtask

   // Sends the first nbits bits of a frame (11 = complete frame).
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int nbits);
      logic [10:0] bits;
      bit          dlv;
      logic        rdy1;
      bits = {stop, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         drive_fall(bits[i]);
         @(negedge clk);
         dlv = 1'b0;
         if (i == 10) begin
            #1;
            predict(b, par, stop, dlv);
         end
         @(negedge clk);
         last_fall_cyc = cyc;
         check($sformatf("busy_bit%0d", i), busy, (i != 10) ? 1 : 0);
         if (dlv) begin
            check("latency_valid", rx_valid, 1);
            check("latency_data", rx_data, b);
            rdy1 = rx_ready;
            @(negedge clk);
            if (rdy1) check("valid_after_accept", rx_valid, 0);
         end
         release_clk();
      end
      ps2_data = 1'b1;
   endtask

   function automatic logic good_par(input logic [7:0] b);
      return ($countones(b) % 2) == 0;
   endfunction

   initial begin
      bit          seen;
      logic [7:0]  b;
      int unsigned kind;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rx_data", rx_data, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_errs", {err_parity, err_frame, err_timeout, err_overrun}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);

      // Single 0x1C frame, consumer always ready
      rdy_fixed = 1'b1;
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      repeat (10) @(posedge clk);

      // Back-to-back with consumer stalled: second byte overruns
      rdy_fixed = 1'b0;
      repeat (3) @(posedge clk);
      send_frame(8'hF0, 1'b1, 1'b1, 11);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      @(negedge clk);
      check("overrun_held_data", rx_data, 8'hF0);
      check("overrun_held_valid", rx_valid, 1);
      rdy_fixed = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rx_ready === 1'b1) break;
      end
      @(negedge clk);
      check("valid_falls_after_ready", rx_valid, 0);

      // Bad parity bit
      send_frame(8'h1C, 1'b1, 1'b1, 11);
      repeat (5) @(posedge clk);

      // Bad stop bit, then a clean frame
      send_frame(8'h55, 1'b1, 1'b0, 11);
      send_frame(8'h55, 1'b1, 1'b1, 11);

      // Glitch: fall with data high while idle
      drive_fall(1'b1);
      @(negedge clk);
      @(negedge clk);
      check("glitch_busy", busy, 0);
      release_clk();

      // Stall after 4 data bits
      send_frame(8'hA6, 1'b0, 1'b1, 5);
      exp_errs.push_back(E_TIMEOUT);
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk);
         if (err_timeout === 1'b1) begin
            seen = 1'b1;
            check("timeout_delay", cyc - last_fall_cyc, TMO);
         end
      end
      check("timeout_seen", seen, 1);
      @(negedge clk);
      check("timeout_busy", busy, 0);
      check("timeout_valid", rx_valid, 0);
      send_frame(8'h3B, good_par(8'h3B), 1'b1, 11);

      // Reset after 5 data bits
      send_frame(8'h7E, 1'b0, 1'b1, 6);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midreset_rx_data", rx_data, 0);
      check("midreset_valid_busy", {rx_valid, busy}, 0);
      check("midreset_errs", {err_parity, err_frame, err_timeout, err_overrun}, 0);
      model_full = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      send_frame(8'h1C, 1'b0, 1'b1, 11);

      // Randomized frames with a randomly stalling consumer
      rdy_rand = 1'b1;
      for (int f = 0; f < 30; f++) begin
         b    = 8'($urandom);
         kind = $urandom_range(0, 9);
         if (kind == 0)      send_frame(b, good_par(b), 1'b0, 11);
         else if (kind == 1) send_frame(b, ~good_par(b), 1'b1, 11);
         else                send_frame(b, good_par(b), 1'b1, 11);
         repeat ($urandom_range(0, 30)) @(posedge clk);
      end

      // Drain
      rdy_rand  = 1'b0;
      rdy_fixed = 1'b1;
      for (int k = 0; k < 50 && exp_bytes.size() != 0; k++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("bytes_outstanding", exp_bytes.size(), 0);
      check("errors_outstanding", exp_errs.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
Frame-receive controller for the PS/2 keyboard path. It consumes the debounced PS/2 clock and data lines from the debouncer instances and sequences the 11-bit device-to-host frame: start, 8 data LSB-first, odd parity, stop. It presents each received scan-code byte on a valid/ready handshake to the downstream scan-code decoder and reports protocol errors as one-cycle pulses.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz); must be >= 2
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ps2_clk  in  1  debounced PS/2 clock, already synchronous to clk
ps2_data  in  1  debounced PS/2 data, already synchronous to clk
rx_data  out  8  received byte; valid while rx_valid=1
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts rx_data when rx_valid&rx_ready
busy  out  1  1 when state != IDLE
err_parity  out  1  one-cycle pulse: parity mismatch
err_frame  out  1  one-cycle pulse: stop bit sampled 0
err_timeout  out  1  one-cycle pulse: frame abandoned on timeout
err_overrun  out  1  one-cycle pulse: completed byte dropped, holding register full

Behaviour:
- Reset, synchronous on clk when rst=1: state=IDLE, clk_prev=1, bit_cnt=0, shift=0, tmo_cnt=0, rx_data=0x00, rx_valid=0, all err_*=0. Reset mid-frame discards the partial frame silently.
- Edge detect: fall = clk_prev & ~ps2_clk, with clk_prev <= ps2_clk every cycle. ps2_data is sampled in the same cycle that fall=1.
- FSM, all transitions on fall unless noted:
  - IDLE: data=0 -> DATA, bit_cnt=0, tmo_cnt=0. data=1 -> stay; glitch, no error.
  - DATA: shift <= {ps2_data, shift[7:1]}, bit_cnt++. On the 8th bit (bit_cnt 7 -> 8) go to PARITY.
  - PARITY: par <= ps2_data -> STOP.
  - STOP: go to IDLE, then evaluate:
    - ps2_data=0 -> err_frame pulse, byte dropped.
    - Otherwise, parity bad (see Optional Feature) -> err_parity pulse, byte dropped.
    - Otherwise -> deliver the byte.
    - If frame and parity are both bad, only err_frame pulses.
- Timeout: in any state except IDLE, tmo_cnt clears on fall and otherwise increments. When tmo_cnt reaches TIMEOUT_CYCLES-1 with no fall: state=IDLE, err_timeout pulses next cycle, partial byte discarded. The counter is held at 0 in IDLE.
- Deliver:
  - rx_valid=0, or rx_ready=1 in the same cycle: rx_data <= shift, rx_valid=1 in the next cycle. Latency is 1 clk from the stop-bit fall.
  - rx_valid=1 and rx_ready=0: the new byte is dropped, err_overrun pulses, and rx_data/rx_valid are unchanged.
- Handshake: rx_valid&rx_ready with no simultaneous delivery -> rx_valid=0 next cycle. rx_data and rx_valid are stable while rx_valid=1 and rx_ready=0.
- busy = (state != IDLE), registered with the state.
- All err_* pulses are registered and last exactly one cycle.

Optional Feature:
- Macro: PS2_RX_PARITY_CHECK_EN
- Defined: parity is good iff ^{shift, par} == 1 (odd parity). A mismatch drops the byte and pulses err_parity.
- Undefined: the parity bit is still clocked through the PARITY state but ignored. err_parity is tied to 0. The frame is still 11 bits.

Test Plan:
- Scan-code 0x1C: start 0; bits 0,0,1,1,1,0,0,0; parity 0; stop 1; ps2_clk period 40 clk, rx_ready=1 -> rx_valid for 1 cycle with rx_data=0x1C, 1 clk after the stop-bit fall; busy high from the start-bit fall to the stop-bit fall.
- Back-to-back 0xF0 (parity 1) then 0x1C, rx_ready=0 -> rx_data=0xF0 held; err_overrun pulses at the 0x1C stop bit. Then rx_ready=1 -> rx_valid falls next cycle.
- Frame 0x1C with parity bit 1, macro defined -> err_parity pulse, no rx_valid. Macro undefined -> rx_data=0x1C delivered, err_parity stays 0.
- Frame 0x55 with stop bit 0 -> err_frame pulse only, no rx_valid, state back to IDLE; a following valid 0x55 frame is received correctly.
- ps2_clk stops high after 4 data bits, TIMEOUT_CYCLES=100 -> err_timeout pulses about 100 clk after the last fall, busy=0, no rx_valid; the next full frame is received.
- rst=1 asserted after 5 data bits -> all outputs 0, busy=0 next cycle, no err_* pulses; the following frame 0x1C is received normally.
